render_sequencer: RTL and testbench

Frame-level controller that sequences one rendered frame through the rasterizer and the display framebuffer/depth buffer. It clears the display buffers, fetches N triangles from a triangle memory, issues them to the rasterizer over a valid/ready handshake, waits for rasterization to finish, and then synchronises completion to the display frame pulse. It sits between the frame source (CPU or testbench) and the `rasterizer`/`display` pair, replacing hand-driven `i_triangle_dv`/`clear` strobes.

---
 rtl/render_pkg.sv | 22 ++
 rtl/render_sequencer.sv | 117 +++++++++++
 tb/tb_render_sequencer.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/render_pkg.sv
// Shared types for the frame render sequencer: FSM state encoding, vertex
// word layout and default triangle memory depth.
package render_pkg;

    localparam int MAX_TRIANGLES_DEF = 16;
    localparam int DATAWIDTH_DEF     = 12;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_WAIT_CLEAR,
        S_FETCH,
        S_LOAD,
        S_ISSUE,
        S_WAIT_RAST,
        S_WAIT_FRAME
    } render_state_t;

    // One vertex packed as {x, y, z}, each a signed DATAWIDTH field.
    typedef logic signed [3*DATAWIDTH_DEF-1:0] vertex_t;

endpackage

// File: rtl/render_sequencer.sv
// Frame controller: clears the display, streams N triangles from external
// memory to the rasterizer, then aligns completion to the display frame pulse.
module render_sequencer
    import render_pkg::*;
#(
    parameter int DATAWIDTH     = DATAWIDTH_DEF,
    parameter int COLORWIDTH    = 4,
    parameter int MAX_TRIANGLES = MAX_TRIANGLES_DEF,
    parameter int IDXWIDTH      = $clog2(MAX_TRIANGLES)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_start,
    input  logic [IDXWIDTH:0]             i_num_triangles,
    output logic [IDXWIDTH-1:0]           o_tri_rd_addr,
    input  logic signed [3*DATAWIDTH-1:0] i_tri_v0,
    input  logic signed [3*DATAWIDTH-1:0] i_tri_v1,
    input  logic signed [3*DATAWIDTH-1:0] i_tri_v2,
    input  logic [COLORWIDTH-1:0]         i_tri_color,
    output logic                          o_clear,
    input  logic                          i_display_ready,
    output logic signed [3*DATAWIDTH-1:0] o_v0,
    output logic signed [3*DATAWIDTH-1:0] o_v1,
    output logic signed [3*DATAWIDTH-1:0] o_v2,
    output logic [COLORWIDTH-1:0]         o_color,
    output logic                          o_triangle_dv,
    output logic                          o_triangle_last,
    input  logic                          i_rast_ready,
    input  logic                          i_rast_finished,
    input  logic                          i_frame,
    output logic                          o_busy,
    output logic                          o_frame_done
);

    localparam logic [IDXWIDTH:0] MAX_N = (IDXWIDTH+1)'(MAX_TRIANGLES);
    localparam logic [IDXWIDTH:0] ONE   = (IDXWIDTH+1)'(1);

    render_state_t     state, state_nx;
    logic [IDXWIDTH:0] n;
    logic [IDXWIDTH:0] idx;
    logic              clear_seen;

    function automatic logic [IDXWIDTH:0] sat_count(input logic [IDXWIDTH:0] req);
        return (req > MAX_N) ? MAX_N : req;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        o_clear       = 1'b0;
        o_triangle_dv = 1'b0;
        o_busy        = 1'b1;
        case (state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_start) state_nx = S_CLEAR;
            end
            S_CLEAR: begin
                o_clear  = 1'b1;
                state_nx = S_WAIT_CLEAR;
            end
            S_WAIT_CLEAR: begin
                // The display may still report ready from before the clear landed.
                if (clear_seen && i_display_ready)
                    state_nx = (n != '0) ? S_FETCH : S_WAIT_FRAME;
            end
            S_FETCH: state_nx = S_LOAD;
            S_LOAD:  state_nx = S_ISSUE;
            S_ISSUE: begin
                o_triangle_dv = 1'b1;
                if (i_rast_ready)
                    state_nx = o_triangle_last ? S_WAIT_RAST : S_FETCH;
            end
            S_WAIT_RAST: if (i_rast_finished) state_nx = S_WAIT_FRAME;
            S_WAIT_FRAME: if (i_frame) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    assign o_tri_rd_addr = idx[IDXWIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n               <= '0;
            idx             <= '0;
            clear_seen      <= 1'b0;
            o_v0            <= '0;
            o_v1            <= '0;
            o_v2            <= '0;
            o_color         <= '0;
            o_triangle_last <= 1'b0;
            o_frame_done    <= 1'b0;
        end else begin
            clear_seen   <= (state == S_WAIT_CLEAR);
            o_frame_done <= (state == S_WAIT_FRAME) && i_frame;
            if (state == S_IDLE && i_start) begin
                n   <= sat_count(i_num_triangles);
                idx <= '0;
            end
            // Memory data for the address driven in FETCH is valid during LOAD.
            if (state == S_LOAD) begin
                o_v0            <= i_tri_v0;
                o_v1            <= i_tri_v1;
                o_v2            <= i_tri_v2;
                o_color         <= i_tri_color;
                o_triangle_last <= (idx == n - ONE);
            end
            if (state == S_ISSUE && i_rast_ready && !o_triangle_last)
                idx <= idx + ONE;
        end
    end

endmodule

// File: tb/tb_render_sequencer.sv
// Directed bench for render_sequencer with a 1-cycle-latency triangle memory
// whose contents are a closed-form function of the address.
module tb_render_sequencer;
    import render_pkg::*;

    localparam int DW  = 12;
    localparam int CW  = 4;
    localparam int MAX = 16;
    localparam int IW  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_start = 1'b0;
    logic [IW:0]   i_num_triangles = '0;
    logic [IW-1:0] o_tri_rd_addr;
    vertex_t       i_tri_v0, i_tri_v1, i_tri_v2;
    logic [CW-1:0] i_tri_color;
    logic          o_clear;
    logic          i_display_ready = 1'b1;
    vertex_t       o_v0, o_v1, o_v2;
    logic [CW-1:0] o_color;
    logic          o_triangle_dv, o_triangle_last;
    logic          i_rast_ready = 1'b1;
    logic          i_rast_finished = 1'b0;
    logic          i_frame = 1'b0;
    logic          o_busy, o_frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    vertex_t       q_v0[$], q_v1[$], q_v2[$];
    logic [CW-1:0] q_col[$];
    logic          q_last[$];
    int            clears = 0;
    int            dones  = 0;

    render_sequencer #(
        .DATAWIDTH(DW), .COLORWIDTH(CW), .MAX_TRIANGLES(MAX), .IDXWIDTH(IW)
    ) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_num_triangles(i_num_triangles),
        .o_tri_rd_addr(o_tri_rd_addr), .i_tri_v0(i_tri_v0), .i_tri_v1(i_tri_v1),
        .i_tri_v2(i_tri_v2), .i_tri_color(i_tri_color), .o_clear(o_clear),
        .i_display_ready(i_display_ready), .o_v0(o_v0), .o_v1(o_v1), .o_v2(o_v2),
        .o_color(o_color), .o_triangle_dv(o_triangle_dv), .o_triangle_last(o_triangle_last),
        .i_rast_ready(i_rast_ready), .i_rast_finished(i_rast_finished), .i_frame(i_frame),
        .o_busy(o_busy), .o_frame_done(o_frame_done)
    );

    always #5 clk = ~clk;

    function automatic vertex_t exp_v0(input int k);
        return {12'(k + 10), 12'(k + 20), 12'(-(k + 1))};
    endfunction
    function automatic vertex_t exp_v1(input int k);
        return {12'(-(k + 30)), 12'(k * 2), 12'(100)};
    endfunction
    function automatic vertex_t exp_v2(input int k);
        return {12'(k * 3 + 5), 12'(-7), 12'(k)};
    endfunction
    function automatic logic [CW-1:0] exp_col(input int k);
        return CW'(k) ^ 4'h5;
    endfunction

    // Synchronous-read triangle memory
    always @(posedge clk) begin
        i_tri_v0    <= exp_v0(int'(o_tri_rd_addr));
        i_tri_v1    <= exp_v1(int'(o_tri_rd_addr));
        i_tri_v2    <= exp_v2(int'(o_tri_rd_addr));
        i_tri_color <= exp_col(int'(o_tri_rd_addr));
    end

    always @(negedge clk) begin
        if (o_triangle_dv && i_rast_ready) begin
            q_v0.push_back(o_v0);
            q_v1.push_back(o_v1);
            q_v2.push_back(o_v2);
            q_col.push_back(o_color);
            q_last.push_back(o_triangle_last);
        end
        if (o_clear)      clears++;
        if (o_frame_done) dones++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input int num);
        i_start = 1'b1;
        i_num_triangles = (IW+1)'(num);
        tick();
        i_start = 1'b0;
        check("clear_at_t1", o_clear, 1);
        check("busy_at_t1", o_busy, 1);
        tick();
        check("clear_one_cycle", o_clear, 0);
    endtask

    task automatic wait_xfers(input string tag, input int target);
        for (int i = 0; i < 400 && q_v0.size() < target; i++) tick();
        check(tag, q_v0.size(), target);
    endtask

    task automatic wait_dv(input string tag);
        for (int i = 0; i < 50 && !o_triangle_dv; i++) tick();
        check(tag, o_triangle_dv, 1);
    endtask

    task automatic verify_frame(input string tag, input int base, input int num);
        for (int k = 0; k < num; k++) begin
            check($sformatf("%s_v0_%0d", tag, k), q_v0[base+k], exp_v0(k));
            check($sformatf("%s_v1_%0d", tag, k), q_v1[base+k], exp_v1(k));
            check($sformatf("%s_v2_%0d", tag, k), q_v2[base+k], exp_v2(k));
            check($sformatf("%s_col_%0d", tag, k), q_col[base+k], exp_col(k));
            check($sformatf("%s_last_%0d", tag, k), q_last[base+k], (k == num - 1));
        end
    endtask

    task automatic finish_frame(input string tag, input int cbase, input int dbase);
        repeat (3) tick();
        i_rast_finished = 1'b1;
        tick();
        i_rast_finished = 1'b0;
        check({tag, "_busy_pre"}, o_busy, 1);
        check({tag, "_done_pre"}, o_frame_done, 0);
        i_frame = 1'b1;
        tick();
        i_frame = 1'b0;
        check({tag, "_done_pulse"}, o_frame_done, 1);
        check({tag, "_busy_fall"}, o_busy, 0);
        tick();
        check({tag, "_done_low"}, o_frame_done, 0);
        check({tag, "_clear_cnt"}, clears - cbase, 1);
        check({tag, "_done_cnt"}, dones - dbase, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, cb, db;

        // Reset state
        #1;
        check("rst_busy", o_busy, 0);
        check("rst_dv", o_triangle_dv, 0);
        check("rst_clear", o_clear, 0);
        check("rst_v0", o_v0, 0);
        check("rst_addr", o_tri_rd_addr, 0);
        check("rst_done", o_frame_done, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tick();

        // Two triangles, rasterizer always ready
        base = q_v0.size(); cb = clears; db = dones;
        start_frame(2);
        wait_xfers("n2_count", base + 2);
        verify_frame("n2", base, 2);
        finish_frame("n2", cb, db);

        // Three triangles, stall on triangle 1
        base = q_v0.size(); cb = clears; db = dones;
        start_frame(3);
        wait_xfers("n3_first", base + 1);
        i_rast_ready = 1'b0;
        wait_dv("n3_dv_seen");
        for (int c = 0; c < 5; c++) begin
            check($sformatf("n3_hold_dv_%0d", c), o_triangle_dv, 1);
            check($sformatf("n3_hold_v0_%0d", c), o_v0, exp_v0(1));
            tick();
        end
        i_rast_ready = 1'b1;
        check("n3_hold_dv_5", o_triangle_dv, 1);
        check("n3_hold_v1_5", o_v1, exp_v1(1));
        wait_xfers("n3_count", base + 3);
        verify_frame("n3", base, 3);
        finish_frame("n3", cb, db);

        // Empty frame
        base = q_v0.size(); cb = clears; db = dones;
        start_frame(0);
        finish_frame("n0", cb, db);
        check("n0_no_dv", q_v0.size() - base, 0);

        // Oversized count saturates
        base = q_v0.size(); cb = clears; db = dones;
        start_frame(20);
        wait_xfers("n20_count", base + 16);
        verify_frame("n20", base, 16);
        finish_frame("n20", cb, db);

        // Stray start during ISSUE and stray frame during WAIT_RAST
        base = q_v0.size(); cb = clears; db = dones;
        i_rast_ready = 1'b0;
        start_frame(2);
        wait_dv("ign_dv_seen");
        i_start = 1'b1;
        i_num_triangles = 5'd5;
        tick();
        i_start = 1'b0;
        i_rast_ready = 1'b1;
        wait_xfers("ign_count", base + 2);
        i_frame = 1'b1;
        tick();
        i_frame = 1'b0;
        check("ign_frame_done", o_frame_done, 0);
        check("ign_frame_busy", o_busy, 1);
        tick();
        check("ign_frame_done2", o_frame_done, 0);
        finish_frame("ign", cb, db);
        verify_frame("ign", base, 2);
        check("ign_total", q_v0.size() - base, 2);

        // Asynchronous reset during ISSUE
        base = q_v0.size(); cb = clears;
        i_rast_ready = 1'b0;
        start_frame(3);
        wait_dv("rst_dv_seen");
        #2 rst = 1'b1;
        #1;
        check("mid_rst_dv", o_triangle_dv, 0);
        check("mid_rst_busy", o_busy, 0);
        check("mid_rst_v0", o_v0, 0);
        check("mid_rst_color", o_color, 0);
        check("mid_rst_last", o_triangle_last, 0);
        check("mid_rst_addr", o_tri_rd_addr, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) tick();
        check("post_rst_no_clear", clears - cb, 1);
        check("post_rst_idle", o_busy, 0);
        check("post_rst_no_xfer", q_v0.size() - base, 0);
        i_rast_ready = 1'b1;
        base = q_v0.size(); cb = clears; db = dones;
        start_frame(2);
        wait_xfers("post_rst_count", base + 2);
        verify_frame("post_rst", base, 2);
        finish_frame("post_rst", cb, db);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
